program_counter: RTL
====================

# program_counter

Program counter stage driven directly by the fetch controller's active-low strobes (`pc_read_n`, `pc_write_n`, `pc_inc_n`, `halt`). It holds the current instruction address and drives it onto the internal data bus on request. It loads a new address from the bus and increments with wrap-around. It also keeps a small return-address stack for call/return, with sticky error reporting for illegal strobe combinations and stack misuse.

## Interface
Parameters:
- `WIDTH`, 8: address/data-bus width in bits (4..16).
- `STACK_DEPTH`, 4: return-stack entries, power of two, 2..16.

Ports:
- `i_clk`  in  1  system clock, rising-edge.
- `i_reset_n`  in  1  reset, asynchronous, active-low.
- `i_halt`  in  1  freeze: no state change while high.
- `i_pc_read_n`  in  1  active-low: drive PC onto `o_bus`.
- `i_pc_write_n`  in  1  active-low: load PC from `i_bus`.
- `i_pc_inc_n`  in  1  active-low: PC <= PC + 1.
- `i_call_n`  in  1  active-low: push PC+1, load PC from `i_bus`.
- `i_ret_n`  in  1  active-low: pop stack into PC.
- `i_bus`  in  WIDTH  bus data for write/call.
- `o_bus`  out  WIDTH  PC value when reading, else 0.
- `o_bus_oe`  out  1  high while `i_pc_read_n` is low.
- `o_pc`  out  WIDTH  current PC register.
- `o_stack_empty`  out  1  stack holds 0 entries.
- `o_stack_full`  out  1  stack holds `STACK_DEPTH` entries.
- `o_error`  out  1  sticky fault flag, cleared only by reset.

## Operation
- Reset, asynchronous and immediate: `o_pc`=0, stack pointer=0, `o_stack_empty`=1, `o_stack_full`=0, `o_error`=0. `o_bus`/`o_bus_oe` follow `i_pc_read_n`, so they are 0 when it is high.
- Read path is combinational. `o_bus_oe` = !`i_pc_read_n`. `o_bus` = `o_pc` when `o_bus_oe` is high, else 0. Read works during halt and alongside any update, and always shows the pre-edge PC.
- Update ops are decoded each edge with priority halt > write > ret > call > inc:
  - write: PC <= `i_bus`.
  - ret: if the stack is non-empty, PC <= top and the stack pops. If empty, PC is unchanged and `o_error` sets.
  - call: if the stack is not full, push (PC+1) mod 2^WIDTH and PC <= `i_bus`. If full, the whole call is ignored (no push, no jump) and `o_error` sets.
  - inc: PC <= (PC+1) mod 2^WIDTH. 2^WIDTH−1 wraps to 0 with no error.
  - none: hold.
- Conflict: if two or more of write/ret/call/inc are low in the same cycle, only the highest-priority op executes and `o_error` sets. The check is suppressed while `i_halt`=1.
- `i_halt`=1 blocks all PC, stack and error updates. The read path stays active.
- `o_stack_empty`/`o_stack_full` are derived from the registered stack pointer.

## Timing
- All state updates happen on the rising edge of `i_clk`.
- `o_pc` shows the new value one cycle after the strobe is sampled low.
- Read has zero latency, combinational from `i_pc_read_n`.
- Controller sequence read(cycle 0) → inc(cycle 1): the bus shows N in cycle 0, and `o_pc`=N+1 after the cycle-1 edge.
- Call/ret finish in a single cycle. A call directly after a ret (or the reverse) on back-to-back cycles sees the updated pointer.
- Stack flags and `o_error` are registered, valid the cycle after the causing edge.

## Structure
- Package `pc_pkg`:
  - op enum `PC_OP_NONE`, `PC_OP_LOAD`, `PC_OP_RET`, `PC_OP_CALL`, `PC_OP_INC`.
  - default `WIDTH`/`STACK_DEPTH` constants.
  - priority-decode function returning op plus conflict flag.
- Sub-module `pc_stack`: LIFO of `STACK_DEPTH`×`WIDTH`.
  - Ports: push, pop, push data, top, empty, full.
  - Pointer width is log2(`STACK_DEPTH`)+1.
  - Same clock and async active-low reset.

## Test plan
- Reset then 3× (read, inc) → bus shows 0, 1, 2 in the read cycles; `o_pc`=3; `o_error`=0.
- WIDTH=8, write 0xFE, then inc, inc → `o_pc` goes 0xFE, 0xFF, 0x00; no error.
- PC=0x10, call with bus=0x40 → `o_pc`=0x40, `o_stack_empty`=0. Then ret → `o_pc`=0x11, empty=1.
- 4 calls (DEPTH=4) → `o_stack_full`=1. A 5th call with bus=0x99 → PC unchanged, `o_error`=1. Ret on an empty stack after reset → PC unchanged, `o_error`=1.
- Write and inc low together with bus=0x20 → `o_pc`=0x20, `o_error`=1. Same stimulus with `i_halt`=1 → nothing changes, error stays 0.
- Drive `i_reset_n` low mid-call (between edges) → `o_pc`=0, empty=1, error=0 immediately, without a clock edge.

Source files
------------

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - program counter op encoding, defaults and strobe priority decode
package pc_pkg;

  localparam int PC_WIDTH_DEF       = 8;
  localparam int PC_STACK_DEPTH_DEF = 4;

  typedef enum logic [2:0] {
    PC_OP_NONE,
    PC_OP_LOAD,
    PC_OP_RET,
    PC_OP_CALL,
    PC_OP_INC
  } pc_op_e;

  typedef struct packed {
    pc_op_e op;
    logic   conflict;
  } pc_dec_t;

  // Priority halt > write > ret > call > inc; conflict when 2+ update strobes are low.
  function automatic pc_dec_t pc_decode(input logic halt, input logic write_n,
                                        input logic ret_n, input logic call_n,
                                        input logic inc_n);
    pc_dec_t    dec;
    logic [2:0] n_active;
    n_active = 3'(!write_n) + 3'(!ret_n) + 3'(!call_n) + 3'(!inc_n);
    dec.op       = PC_OP_NONE;
    dec.conflict = 1'b0;
    if (!halt) begin
      dec.conflict = (n_active >= 3'd2);
      if (!write_n)     dec.op = PC_OP_LOAD;
      else if (!ret_n)  dec.op = PC_OP_RET;
      else if (!call_n) dec.op = PC_OP_CALL;
      else if (!inc_n)  dec.op = PC_OP_INC;
    end
    return dec;
  endfunction

endpackage

// File: rtl/pc_stack.sv
// rtl/pc_stack.sv - return-address LIFO with registered pointer and empty/full flags
module pc_stack
  import pc_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH_DEF,
  parameter int DEPTH = PC_STACK_DEPTH_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_push_data,
  output logic [WIDTH-1:0] o_top,
  output logic             o_empty,
  output logic             o_full
);

  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = PTR_W - 1;

  logic [PTR_W-1:0] sp_q, sp_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] top_ptr;

  assign top_ptr = sp_q - PTR_W'(1);
  assign o_top   = mem_q[top_ptr[IDX_W-1:0]];
  assign o_empty = (sp_q == '0);
  assign o_full  = (sp_q == PTR_W'(DEPTH));

  // Guards here keep the pointer in range even if a caller ignores the flags.
  always_comb begin
    sp_d  = sp_q;
    mem_d = mem_q;
    if (i_push && !o_full) begin
      mem_d[sp_q[IDX_W-1:0]] = i_push_data;
      sp_d = sp_q + PTR_W'(1);
    end else if (i_pop && !o_empty) begin
      sp_d = sp_q - PTR_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sp_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sp_q  <= sp_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/program_counter.sv
// rtl/program_counter.sv - program counter with bus read/load, increment, call/return stack
module program_counter
  import pc_pkg::*;
#(
  parameter int WIDTH       = PC_WIDTH_DEF,
  parameter int STACK_DEPTH = PC_STACK_DEPTH_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_halt,
  input  logic             i_pc_read_n,
  input  logic             i_pc_write_n,
  input  logic             i_pc_inc_n,
  input  logic             i_call_n,
  input  logic             i_ret_n,
  input  logic [WIDTH-1:0] i_bus,
  output logic [WIDTH-1:0] o_bus,
  output logic             o_bus_oe,
  output logic [WIDTH-1:0] o_pc,
  output logic             o_stack_empty,
  output logic             o_stack_full,
  output logic             o_error
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             error_q, error_d;
  logic [WIDTH-1:0] pc_plus1;
  logic [WIDTH-1:0] stack_top;
  logic             push, pop;
  pc_dec_t          dec;

  assign dec      = pc_decode(i_halt, i_pc_write_n, i_ret_n, i_call_n, i_pc_inc_n);
  assign pc_plus1 = pc_q + WIDTH'(1);
  assign push     = (dec.op == PC_OP_CALL) && !o_stack_full;
  assign pop      = (dec.op == PC_OP_RET) && !o_stack_empty;

  assign o_bus_oe = !i_pc_read_n;
  assign o_bus    = o_bus_oe ? pc_q : '0;
  assign o_pc     = pc_q;
  assign o_error  = error_q;

  // A refused call or ret leaves the PC untouched and only raises the sticky error.
  always_comb begin
    pc_d    = pc_q;
    error_d = error_q | dec.conflict;
    unique case (dec.op)
      PC_OP_LOAD: pc_d = i_bus;
      PC_OP_RET: begin
        if (pop) pc_d = stack_top;
        else     error_d = 1'b1;
      end
      PC_OP_CALL: begin
        if (push) pc_d = i_bus;
        else      error_d = 1'b1;
      end
      PC_OP_INC: pc_d = pc_plus1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pc_q    <= '0;
      error_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      error_q <= error_d;
    end
  end

  pc_stack #(
    .WIDTH(WIDTH),
    .DEPTH(STACK_DEPTH)
  ) u_stack (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_push     (push),
    .i_pop      (pop),
    .i_push_data(pc_plus1),
    .o_top      (stack_top),
    .o_empty    (o_stack_empty),
    .o_full     (o_stack_full)
  );

endmodule
